uart_rx_fifo: RTL and testbench

Memory-side UART receiver for the picorv32 SoC. It turns the serial line driven into the chip back into bytes for the CPU, which makes it the RTL counterpart of the bench's serial monitor on the transmit pin. The block has:
- an input synchroniser;
- a mid-bit sampling receive FSM with a programmable divisor;
- a show-ahead byte FIFO with a valid/ready read port for the bus wrapper.

---
 rtl/uart_rx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, LSB first) with a show-ahead byte FIFO.
//   clk, reset      : system clock, asynchronous active-high reset
//   ser_rx          : serial line, idle high, asynchronous to clk
//   cfg_div_we/di/do: clocks-per-bit register (writes below 4 stored as 4)
//   rx_data/valid   : FIFO head byte and non-empty flag; rx_ready pops
//   fifo_level      : bytes currently held
//   frame_err       : one-cycle pulse on a stop bit sampled low
//   overflow        : sticky drop flag, cleared by overflow_clr (set wins)
module uart_rx_fifo #(
  parameter int unsigned DEFAULT_DIV = 100,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_rx,
  input  logic                          cfg_div_we,
  input  logic [31:0]                   cfg_div_di,
  output logic [31:0]                   cfg_div_do,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic          sync1_q, sync2_q;
  logic [31:0]   div_reg_q, div_reg_d;
  logic [31:0]   div_q, div_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  state_t        state_q, state_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;

  logic          rxs_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic [31:0]   half_m1_s;
  logic [31:0]   div_m1_s;

  assign rxs_s      = sync2_q;
  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign full_s     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rx_valid   = (wptr_q != rptr_q);
  assign pop_s      = rx_valid & rx_ready;
  assign fifo_level = wptr_q - rptr_q;
  assign rx_data    = mem_q[rptr_q[AW-1:0]];
  assign cfg_div_do = div_reg_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign half_m1_s  = (div_q >> 1) - 32'd1;
  assign div_m1_s   = div_q - 32'd1;

  // Next-state logic for the divisor register, receive FSM and FIFO.
  always_comb begin
    div_reg_d   = div_reg_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    state_d     = state_q;
    frame_err_d = 1'b0;
    overflow_d  = overflow_q & ~overflow_clr;
    push_s      = 1'b0;
    mem_d       = mem_q;

    if (cfg_div_we) begin
      div_reg_d = (cfg_div_di < 32'd4) ? 32'd4 : cfg_div_di;
    end else begin
      div_reg_d = div_reg_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs_s) begin
          cnt_d   = 32'd0;
          div_d   = div_reg_q;  // frozen for the whole frame
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == half_m1_s) begin
          if (!rxs_s) begin
            cnt_d     = 32'd0;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end else begin
            state_d   = ST_IDLE;  // too short to be a start bit
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == div_m1_s) begin
          shreg_d   = {rxs_s, shreg_q[7:1]};
          cnt_d     = 32'd0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == div_m1_s) begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;  // leave at mid-stop so a back-to-back start is caught
          if (rxs_s) begin
            // A same-cycle pop frees the slot, so a full FIFO can still accept.
            if (!full_s || pop_s) begin
              push_s = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    if (push_s) begin
      mem_d[wptr_q[AW-1:0]] = shreg_q;
    end else begin
      mem_d[wptr_q[AW-1:0]] = mem_q[wptr_q[AW-1:0]];
    end
    wptr_d = wptr_q + {{AW{1'b0}}, push_s};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_s};
  end

  // State registers, synchroniser included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      div_reg_q   <= DEFAULT_DIV;
      div_q       <= DEFAULT_DIV;
      cnt_q       <= 32'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      state_q     <= ST_IDLE;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      sync1_q     <= ser_rx;
      sync2_q     <= sync1_q;
      div_reg_q   <= div_reg_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// batches, checked against a queue-based model of the received byte stream.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_rx;
  logic        cfg_div_we;
  logic [31:0] cfg_div_di;
  logic [31:0] cfg_div_do;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  fifo_level;
  logic        frame_err;
  logic        overflow;
  logic        overflow_clr;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int          fe_cnt = 0;
  logic        prev_valid = 1'b0;
  int unsigned rise_cyc = 0;

  logic [7:0]  mq[$];
  logic        exp_ovf = 1'b0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .ser_rx(ser_rx),
    .cfg_div_we(cfg_div_we), .cfg_div_di(cfg_div_di), .cfg_div_do(cfg_div_do),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample on the falling edge: frame_err high cycles and rx_valid rise time.
  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame, each bit held for div clocks.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int unsigned div);
    ser_rx = 1'b0;
    repeat (div) tick();
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (div) tick();
    end
    ser_rx = stop_bit;
    repeat (div) tick();
    ser_rx = 1'b1;
  endtask

  task automatic set_div(input logic [31:0] v);
    cfg_div_di = v;
    cfg_div_we = 1'b1;
    tick();
    cfg_div_we = 1'b0;
  endtask

  // Model: a good frame is queued if there is room, else it raises overflow.
  task automatic model_rx(input logic [7:0] b);
    if (mq.size() < 8) mq.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_chk(tag, mq.pop_front());
    chk({tag, "_empty_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_empty_valid"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    int unsigned c0;
    int          fe0;
    int unsigned dv;
    int          n;
    int          fe_exp;
    logic [7:0]  b;
    logic        good;

    reset = 1'b1; ser_rx = 1'b1; cfg_div_we = 1'b0; cfg_div_di = 32'd0;
    rx_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_div", cfg_div_do, 32'd100);
    reset = 1'b0;
    repeat (3) tick();

    // Back-to-back 0x55, 0xA3 at div=100, with latency to rx_valid.
    fe0 = fe_cnt;
    c0 = cyc;
    send(8'h55, 1'b1, 100);
    send(8'hA3, 1'b1, 100);
    repeat (20) tick();
    chk("b2b_latency", rise_cyc - c0, 32'd953);
    chk("b2b_level", 32'(fifo_level), 32'd2);
    chk("b2b_ferr", 32'(fe_cnt - fe0), 32'd0);
    model_rx(8'h55);
    model_rx(8'hA3);
    drain("b2b_pop");

    // Short low glitch is rejected.
    ser_rx = 1'b0;
    repeat (20) tick();
    ser_rx = 1'b1;
    repeat (200) tick();
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_level", 32'(fifo_level), 32'd0);
    chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

    // Bad stop bit, then a good frame.
    fe0 = fe_cnt;
    send(8'h3C, 1'b0, 100);
    repeat (200) tick();
    chk("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_level", 32'(fifo_level), 32'd0);
    send(8'h81, 1'b1, 100);
    repeat (20) tick();
    model_rx(8'h81);
    chk("ferr_next_level", 32'(fifo_level), 32'(mq.size()));
    drain("ferr_next");

    // Overflow with 9 bytes, then clear and drain.
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), 1'b1, 100);
      model_rx(8'(i));
    end
    repeat (5) tick();
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_set", 32'(overflow), 32'(exp_ovf));
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    drain("ovf_pop");

    // Refill, then push and pop in the same cycle at full.
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 1'b1, 100);
      model_rx(8'h10 + 8'(i));
    end
    chk("full_level", 32'(fifo_level), 32'd8);
    fork
      send(8'hEE, 1'b1, 100);
      begin
        repeat (952) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'hEE);
    repeat (5) tick();
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    chk("pushpop_level", 32'(fifo_level), 32'd8);
    drain("pushpop");

    // Divisor clamp and mid-frame change.
    set_div(32'd2);
    chk("div_clamp", cfg_div_do, 32'd4);
    set_div(32'd5);
    chk("div_verbatim", cfg_div_do, 32'd5);
    set_div(32'd100);
    fork
      send(8'hC5, 1'b1, 100);
      begin
        repeat (300) tick();
        set_div(32'd16);
      end
    join
    chk("div_mid", cfg_div_do, 32'd16);
    model_rx(8'hC5);
    repeat (10) tick();
    send(8'hF0, 1'b1, 16);
    model_rx(8'hF0);
    repeat (10) tick();
    drain("div_frames");

    // Reset mid-frame with 3 bytes queued.
    for (int i = 0; i < 3; i++) begin
      send(8'hA0 + 8'(i), 1'b1, 16);
      model_rx(8'hA0 + 8'(i));
    end
    chk("prerst_level", 32'(fifo_level), 32'd3);
    fork
      send(8'hF0, 1'b1, 16);
      begin
        repeat (72) tick();
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_div", cfg_div_do, 32'd100);
        repeat (28) tick();
        reset = 1'b0;
      end
    join
    mq.delete();
    exp_ovf = 1'b0;
    repeat (50) tick();
    chk("postrst_level", 32'(fifo_level), 32'd0);
    send(8'h7E, 1'b1, 100);
    model_rx(8'h7E);
    repeat (10) tick();
    drain("postrst");

    // Randomized batches at random divisors, rx_ready held low.
    for (int bt = 0; bt < 4; bt++) begin
      dv = 8 + 2 * $urandom_range(0, 8);
      set_div(dv);
      fe0 = fe_cnt;
      fe_exp = 0;
      n = int'($urandom_range(1, 10));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        good = ($urandom_range(0, 7) != 0);
        send(b, good, dv);
        if (good) begin
          model_rx(b);
        end else begin
          fe_exp++;
          repeat (2 * dv) tick();
        end
      end
      repeat (20) tick();
      chk("rnd_level", 32'(fifo_level), 32'(mq.size()));
      chk("rnd_ovf", 32'(overflow), 32'(exp_ovf));
      chk("rnd_ferr", 32'(fe_cnt - fe0), 32'(fe_exp));
      drain("rnd_pop");
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      exp_ovf = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
